// File: rtl/score_event_scheduler.sv
// Score event scheduler: buffers per-lane hits in saturating counters and drains
// them round-robin as spaced increment pulses to the score register.
module score_event_scheduler #(
   parameter int unsigned LANES          = 4,
   parameter int unsigned PEND_W         = 3,
   parameter int unsigned PULSES_PER_HIT = 2,
   parameter int unsigned GAP            = 1,
   parameter int unsigned MAX_MISSES     = 3
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             startn,
   input  logic             game_idle,
   input  logic             game_active,
   input  logic [LANES-1:0] hit,
   input  logic [LANES-1:0] miss,
   output logic             increment,
   output logic [2:0]       grant_lane,
   output logic             busy,
   output logic             pending_any,
   output logic             overflow,
   output logic [2:0]       miss_count,
   output logic             game_over
);

   typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   localparam logic [2:0]        PPH      = 3'(PULSES_PER_HIT);
   localparam logic [2:0]        MISS_MAX = 3'(MAX_MISSES);
   localparam logic [1:0]        GAP_MID  = 2'(GAP - 1);
   localparam logic [1:0]        GAP_END  = 2'((GAP > 1) ? GAP - 2 : 0);

   state_t            state, state_n;
   logic [PEND_W-1:0] pend [LANES];
   logic [LANES-1:0]  pend_inc, pend_dec;
   logic [2:0]        last_grant, grant_n, sel_hi, sel_lo, sel_lane;
   logic [2:0]        pulse_cnt, pulse_n, miss_n;
   logic [1:0]        gap_cnt, gap_n;
   logic              clear, accept, found_hi, found_lo, drain;

   assign clear       = !resetn || (!startn && game_idle);
   assign accept      = game_active && !game_over;
   assign busy        = (state != S_IDLE);
   assign pending_any = found_lo;

   // First nonzero lane above last_grant, else first nonzero lane overall.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      sel_hi   = '0;
      sel_lo   = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (pend[i] != '0) begin
            if (!found_hi && (3'(i) > last_grant)) begin
               found_hi = 1'b1;
               sel_hi   = 3'(i);
            end
            if (!found_lo) begin
               found_lo = 1'b1;
               sel_lo   = 3'(i);
            end
         end
      end
      sel_lane = found_hi ? sel_hi : sel_lo;
   end

   // pulse_cnt counts pulses started; the drain lands on the edge entering the
   // final pulse, and the IDLE cycle itself serves as one gap cycle after it.
   always_comb begin
      state_n = state;
      grant_n = grant_lane;
      pulse_n = pulse_cnt;
      gap_n   = gap_cnt;
      drain   = 1'b0;
      case (state)
         S_IDLE: begin
            if (found_lo) begin
               state_n = S_PULSE;
               grant_n = sel_lane;
               pulse_n = 3'd1;
               drain   = (PPH == 3'd1);
            end
         end
         S_PULSE: begin
            gap_n = '0;
            if (pulse_cnt == PPH) begin
               state_n = (GAP > 1) ? S_GAP : S_IDLE;
            end else if (GAP > 0) begin
               state_n = S_GAP;
            end else begin
               pulse_n = pulse_cnt + 3'd1;
               drain   = (pulse_n == PPH);
            end
         end
         S_GAP: begin
            if ((pulse_cnt != PPH) && (gap_cnt == GAP_MID)) begin
               state_n = S_PULSE;
               pulse_n = pulse_cnt + 3'd1;
               drain   = (pulse_n == PPH);
            end else if ((pulse_cnt == PPH) && (gap_cnt == GAP_END)) begin
               state_n = S_IDLE;
            end else begin
               gap_n = gap_cnt + 2'd1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      for (int unsigned i = 0; i < LANES; i++) begin
         pend_inc[i] = accept && hit[i];
         pend_dec[i] = drain && (grant_n == 3'(i));
      end
      miss_n = miss_count;
      if (game_active && (miss != '0) && (miss_count != MISS_MAX))
         miss_n = miss_count + 3'd1;
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state      <= S_IDLE;
         increment  <= 1'b0;
         grant_lane <= '0;
         last_grant <= 3'(LANES - 1);
         pulse_cnt  <= '0;
         gap_cnt    <= '0;
         overflow   <= 1'b0;
         miss_count <= '0;
         game_over  <= 1'b0;
         for (int unsigned i = 0; i < LANES; i++) pend[i] <= '0;
      end else begin
         state      <= state_n;
         increment  <= (state_n == S_PULSE);
         grant_lane <= grant_n;
         pulse_cnt  <= pulse_n;
         gap_cnt    <= gap_n;
         miss_count <= miss_n;
         game_over  <= (miss_n == MISS_MAX);
         if (drain) last_grant <= grant_n;
         for (int unsigned i = 0; i < LANES; i++) begin
            if (pend_inc[i] && !pend_dec[i]) begin
               if (pend[i] == PEND_MAX) overflow <= 1'b1;
               else                     pend[i]  <= pend[i] + 1'b1;
            end else if (pend_dec[i] && !pend_inc[i]) begin
               pend[i] <= pend[i] - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_score_event_scheduler.sv
// Bench for score_event_scheduler: timeline reference model feeds an expected
// pulse queue; a negedge monitor pops and compares pulses and status outputs.
module tb_score_event_scheduler;

   localparam int LANES = 4;
   localparam int PEND_W = 3;
   localparam int PPH = 2;
   localparam int GAP = 1;
   localparam int MAXM = 3;
   localparam int MAXP = (1 << PEND_W) - 1;

   logic             clock = 1'b0;
   logic             resetn, startn, game_idle, game_active;
   logic [LANES-1:0] hit, miss;
   logic             increment, busy, pending_any, overflow, game_over;
   logic [2:0]       grant_lane, miss_count;

   typedef struct {
      int cyc;
      int lane;
   } pulse_t;

   pulse_t exp_q[$];
   int     n_cmp = 0;
   int     n_bad = 0;
   int     cyc = 0;
   int     m_pend[LANES];
   int     m_last, m_ovf, m_mc, m_go, m_g, m_ie, m_dec_edge, m_lane;

   always #5 clock = ~clock;

   score_event_scheduler #(
      .LANES(LANES), .PEND_W(PEND_W), .PULSES_PER_HIT(PPH), .GAP(GAP), .MAX_MISSES(MAXM)
   ) dut (
      .clock(clock), .resetn(resetn), .startn(startn), .game_idle(game_idle),
      .game_active(game_active), .hit(hit), .miss(miss), .increment(increment),
      .grant_lane(grant_lane), .busy(busy), .pending_any(pending_any),
      .overflow(overflow), .miss_count(miss_count), .game_over(game_over)
   );

   // Each grant schedules PPH pulses GAP+1 apart; the lane drains on its last
   // pulse and the scheduler may grant again max(GAP,1) cycles after that.
   always @(posedge clock) begin : model
      int     lane, total;
      bit     acc, d;
      pulse_t p;
      cyc++;
      if (!resetn || (!startn && game_idle)) begin
         foreach (m_pend[i]) m_pend[i] = 0;
         m_last = LANES - 1; m_ovf = 0; m_mc = 0; m_go = 0;
         m_g = cyc; m_ie = cyc; m_dec_edge = -1; m_lane = 0;
         exp_q.delete();
      end else begin
         acc = game_active && (m_go == 0);
         total = 0;
         foreach (m_pend[i]) total += m_pend[i];
         if (cyc > m_ie && total > 0) begin
            lane = -1;
            for (int k = 1; k <= LANES; k++)
               if (lane < 0 && m_pend[(m_last + k) % LANES] > 0) lane = (m_last + k) % LANES;
            m_last = lane; m_lane = lane; m_g = cyc;
            m_dec_edge = cyc + (PPH - 1) * (GAP + 1);
            m_ie = m_dec_edge + ((GAP > 1) ? GAP : 1);
            for (int k = 0; k < PPH; k++) begin
               p.cyc = cyc + k * (GAP + 1);
               p.lane = lane;
               exp_q.push_back(p);
            end
         end
         for (int i = 0; i < LANES; i++) begin
            d = (cyc == m_dec_edge) && (i == m_lane);
            if (acc && hit[i]) begin
               if (!d) begin
                  if (m_pend[i] == MAXP) m_ovf = 1;
                  else m_pend[i]++;
               end
            end else if (d) begin
               m_pend[i]--;
            end
         end
         if (game_active && miss != 0 && m_mc < MAXM) m_mc++;
         m_go = (m_mc == MAXM) ? 1 : 0;
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input int exp);
      n_cmp++;
      if (act !== 8'(exp)) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
      end
   endtask

   always @(negedge clock) begin : monitor
      pulse_t e;
      int     any;
      if (cyc > 0) begin
         if (increment === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL pulse at cycle %0d: got increment on lane %0d, required none", cyc, grant_lane);
            end else begin
               e = exp_q.pop_front();
               if (e.cyc != cyc || grant_lane !== 3'(e.lane)) begin
                  n_bad++;
                  $display("FAIL pulse: got cycle %0d lane %0d, required cycle %0d lane %0d",
                           cyc, grant_lane, e.cyc, e.lane);
               end
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pulse at cycle %0d: got no increment, required lane %0d at cycle %0d",
                     cyc, exp_q[0].lane, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
         any = 0;
         foreach (m_pend[i]) if (m_pend[i] != 0) any = 1;
         chk("busy", 8'(busy), (cyc >= m_g && cyc < m_ie) ? 1 : 0);
         chk("pending_any", 8'(pending_any), any);
         chk("overflow", 8'(overflow), m_ovf);
         chk("miss_count", 8'(miss_count), m_mc);
         chk("game_over", 8'(game_over), m_go);
      end
   end

   task automatic step(input logic [LANES-1:0] h, input logic [LANES-1:0] m);
      @(negedge clock);
      hit = h;
      miss = m;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, '0);
   endtask

   task automatic start_key(input logic idle_v);
      @(negedge clock);
      hit = '0; miss = '0; startn = 1'b0; game_idle = idle_v;
      @(negedge clock);
      startn = 1'b1; game_idle = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; startn = 1'b1; game_idle = 1'b0; game_active = 1'b0;
      hit = '0; miss = '0;
      repeat (3) @(negedge clock);
      resetn = 1'b1; game_active = 1'b1;

      step(4'b0001, '0); idle(10);                       // single hit
      step(4'b1111, '0); idle(36);                       // simultaneous hits
      step(4'b0101, '0); step(4'b0001, '0); step(4'b0001, '0); idle(20); // round-robin
      repeat (8) step(4'b0010, '0);                      // saturation
      repeat (12) step(4'b0010, '0);                     // hits on drain edges
      idle(70);

      step(4'b1011, '0); idle(2);
      start_key(1'b0); idle(3);                          // start key outside idle: no effect
      start_key(1'b1); idle(4);                          // start key in idle: clear mid-drain
      step(4'b0110, '0); idle(3);
      @(negedge clock); resetn = 1'b0; hit = '0;
      @(negedge clock);
      @(negedge clock); resetn = 1'b1;
      idle(4);

      for (int i = 0; i < 700; i++) begin
         @(negedge clock);
         hit = '0;
         for (int l = 0; l < LANES; l++) if ($urandom_range(0, 15) == 0) hit[l] = 1'b1;
         miss = ($urandom_range(0, 40) == 0) ? LANES'($urandom_range(1, 15)) : '0;
         game_active = ($urandom_range(0, 9) != 0);
         game_idle = ($urandom_range(0, 3) == 0);
         startn = ($urandom_range(0, 90) != 0);
      end
      @(negedge clock);
      hit = '0; miss = '0; startn = 1'b1; game_idle = 1'b0; game_active = 1'b1;

      start_key(1'b1);                                   // misses to game over
      step(4'b0011, '0); step('0, 4'b0001); step('0, '0);
      step('0, 4'b0110); step('0, 4'b1000);
      step(4'b0100, '0); step('0, 4'b0001);
      idle(40);

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain_done: got %0d outstanding pulses, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
